// File: rtl/wide_add_seq_pkg.sv
// Shared types and constants for the sequential slice-by-slice wide adder.
// Optional subtract support is enabled by defining WIDE_ADD_SEQ_SUB_EN.
package wide_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_N = 4;
    localparam int DEF_K = 4;

    // A single slice still needs a one-bit index register.
    function automatic int idxWidth(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/wide_add_seq_if.sv
// Request/response bundle of wide_add_seq; sub_i exists only when
// WIDE_ADD_SEQ_SUB_EN is defined.
interface wide_add_seq_if
    import wide_add_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int K = DEF_K
) ();

    localparam int W = N * K;

    logic         req_valid_i;
    logic         req_ready_o;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         c_i;
`ifdef WIDE_ADD_SEQ_SUB_EN
    logic         sub_i;
`endif
    logic         rsp_valid_o;
    logic         rsp_ready_i;
    logic [W-1:0] s_o;
    logic         c_o;
    logic         busy_o;

    modport slave (
`ifdef WIDE_ADD_SEQ_SUB_EN
        input  sub_i,
`endif
        input  req_valid_i, a_i, b_i, c_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, s_o, c_o, busy_o
    );

    modport master (
`ifdef WIDE_ADD_SEQ_SUB_EN
        output sub_i,
`endif
        output req_valid_i, a_i, b_i, c_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, s_o, c_o, busy_o
    );

endinterface

// File: rtl/wide_add_seq_add_slice.sv
// N-bit combinational adder slice, time-shared by wide_add_seq across all slices.
module add_slice #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_sum,
    output logic         o_cout
);

    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{N{1'b0}}, i_cin};

endmodule

// File: rtl/wide_add_seq.sv
// Sequential W = N*K bit adder: one N-bit slice per cycle, LSB slice first.
// Define WIDE_ADD_SEQ_SUB_EN to add A - B support through the sub_i request bit.
module wide_add_seq
    import wide_add_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int K = DEF_K
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    wide_add_seq_if.slave  bus
);

    localparam int                W        = N * K;
    localparam int                IDXW     = idxWidth(K);
    localparam logic [IDXW-1:0]   LAST_IDX = IDXW'(K - 1);

    state_e                r_state;
    state_e                w_nextState;
    logic [IDXW-1:0]       r_idx;
    logic [K-1:0][N-1:0]   r_a;
    logic [K-1:0][N-1:0]   r_b;
    logic [K-1:0][N-1:0]   r_sum;
    logic                  r_carry;
    logic                  r_cout;
    logic                  r_sub;

    logic                  w_accept;
    logic                  w_lastSlice;
    logic                  w_subReq;
    logic [N-1:0]          w_aSlice;
    logic [N-1:0]          w_bSlice;
    logic [N-1:0]          w_sliceSum;
    logic                  w_sliceCout;

`ifdef WIDE_ADD_SEQ_SUB_EN
    assign w_subReq = bus.sub_i;
`else
    assign w_subReq = 1'b0;
`endif

    assign w_lastSlice = (r_idx == LAST_IDX);
    assign w_aSlice    = r_a[r_idx];
    assign w_bSlice    = r_sub ? ~r_b[r_idx] : r_b[r_idx];

    add_slice #(.N(N)) u_slice (
        .i_a    (w_aSlice),
        .i_b    (w_bSlice),
        .i_cin  (r_carry),
        .o_sum  (w_sliceSum),
        .o_cout (w_sliceCout)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState     = r_state;
        w_accept        = 1'b0;
        bus.req_ready_o = 1'b0;
        bus.rsp_valid_o = 1'b0;
        bus.busy_o      = 1'b1;
        case (r_state)
            IDLE: begin
                bus.req_ready_o = 1'b1;
                bus.busy_o      = 1'b0;
                w_accept        = bus.req_valid_i;
                if (bus.req_valid_i) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                if (w_lastSlice) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                bus.rsp_valid_o = 1'b1;
                if (bus.rsp_ready_i) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Subtraction is A + ~B + 1, so the initial carry replaces c_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_sub   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a     <= bus.a_i;
                r_b     <= bus.b_i;
                r_sub   <= w_subReq;
                r_carry <= w_subReq ? 1'b1 : bus.c_i;
                r_idx   <= '0;
            end else if (r_state == RUN) begin
                r_sum[r_idx] <= w_sliceSum;
                r_carry      <= w_sliceCout;
                if (w_lastSlice) begin
                    r_cout <= w_sliceCout;
                    r_idx  <= '0;
                end else begin
                    r_idx  <= r_idx + 1'b1;
                end
            end
        end
    end

    assign bus.s_o = r_sum;
    assign bus.c_o = r_cout;

endmodule

// File: doc/wide_add_seq.md
WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

Interface
REQ-001 Parameter: N, default 4, adder slice width in bits (N >= 1).
REQ-002 Parameter: K, default 4, number of slices per operand (K >= 1); operand width W = N*K.
REQ-003 clk_i  input  1  clock; all state updates on the rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid_i  input  1  request valid.
REQ-006 req_ready_o  output  1  request ready.
REQ-007 a_i  input  W  operand A, sampled at request handshake.
REQ-008 b_i  input  W  operand B, sampled at request handshake.
REQ-009 c_i  input  1  carry-in, sampled at request handshake.
REQ-010 sub_i  input  1  subtract select; present only when WIDE_ADD_SEQ_SUB_EN is defined.
REQ-011 rsp_valid_o  output  1  result valid.
REQ-012 rsp_ready_i  input  1  result accepted by consumer.
REQ-013 s_o  output  W  registered sum.
REQ-014 c_o  output  1  registered carry-out of the top slice.
REQ-015 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-016 FSM states SHALL be IDLE, RUN and DONE.
REQ-017 req_ready_o SHALL be 1 only in IDLE.
- IDLE->RUN on req_valid_i && req_ready_o.
- On that transition: latch a_i, b_i and c_i into the operand and carry registers; clear the slice index to 0.
REQ-018 RUN, each cycle:
- Add slice idx (bits idx*N+N-1 : idx*N, LSB slice first) of A and B plus the carry register.
- Write the N-bit sum into s_o slice idx; write the slice carry-out into the carry register.
- Increment idx.
REQ-019 After slice K-1 is written, the state SHALL go RUN->DONE and c_o SHALL take the final carry.
REQ-020 Latency: handshake at edge t gives rsp_valid_o=1 from edge t+K onward (K=1 gives t+1).
REQ-021 DONE SHALL hold rsp_valid_o=1 with s_o and c_o stable until rsp_valid_o && rsp_ready_i; DONE->IDLE on that edge.
REQ-022 A result handshake and a new request SHALL NOT complete in the same cycle; the new request is accepted no earlier than the next cycle, in IDLE.
REQ-023 req_valid_i and operand changes while busy_o=1 SHALL be ignored.
REQ-024 Slice sums SHALL wrap modulo 2^N with carry propagated; W-bit results wrap modulo 2^W.
REQ-025 s_o SHALL retain the last result in IDLE and keep it until the next RUN overwrites it slice by slice.

Reset
REQ-026 While rst_ni=0, the following SHALL be forced:
- state=IDLE, idx=0;
- s_o=0, c_o=0, carry register=0, operand registers=0;
- rsp_valid_o=0, busy_o=0, req_ready_o=1.
REQ-027 Reset asserted mid-RUN or in DONE SHALL abort the operation with no response issued.
REQ-028 First request accepted at the first rising edge after rst_ni deasserts.

Configuration
REQ-029 Macro WIDE_ADD_SEQ_SUB_EN defined:
- sub_i is latched at the request handshake.
- When sub_i=1, each B slice is inverted and the initial carry is forced to 1 (c_i ignored), giving s_o = A - B mod 2^W and c_o = 1 when A >= B unsigned.
REQ-030 Macro undefined: no sub_i port and addition only.

Structure
REQ-031 Package wide_add_pkg SHALL hold:
- the state enum type (IDLE/RUN/DONE);
- default N and K constants;
- the index-width function clog2(K), minimum 1.
REQ-032 Sub-module add_slice: an N-bit combinational adder (a, b, cin -> sum, cout) with one instance, time-shared across slices; all registers SHALL live in wide_add_seq.

Verification (N=4, K=4)
REQ-033 Request A=0x00FF, B=0x0001, c_i=0 -> rsp_valid_o at handshake+4 edges, s_o=0x0100, c_o=0.
REQ-034 Request A=0xFFFF, B=0x0001, c_i=0 -> s_o=0x0000, c_o=1.
REQ-035 Request A=0x1234, B=0x1111, c_i=1; rsp_ready_i held 0 for 5 cycles -> s_o=0x2346 held stable, req_ready_o=0 throughout, DONE->IDLE one edge after rsp_ready_i=1.
REQ-036 rst_ni pulsed low after 2 RUN cycles -> immediate s_o=0, c_o=0, rsp_valid_o=0, req_ready_o=1; no response emitted.
REQ-037 Second request driven during RUN -> ignored; back-to-back requests -> second accepted at the cycle after the result handshake.
REQ-038 With WIDE_ADD_SEQ_SUB_EN: A=0x0005, B=0x0007, sub_i=1 -> s_o=0xFFFE, c_o=0; A=0x0007, B=0x0005 -> s_o=0x0002, c_o=1.
